// File: rtl/stack_pkg.sv
// stack_pkg: command encoding and mod-DEPTH pointer helpers for stack_param
package stack_pkg;
  typedef enum logic [1:0] {CMD_NOP, CMD_PUSH, CMD_POP, CMD_GET} stack_cmd_e;
  function automatic int unsigned ptr_add(input int unsigned p, input int unsigned off, input int unsigned depth);
    return (p + off % depth) % depth;
  endfunction
  function automatic int unsigned ptr_sub(input int unsigned p, input int unsigned off, input int unsigned depth);
    return (p + depth - off % depth) % depth;
  endfunction
endpackage

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x WIDTH register array, one sync write port, one async read port
module stack_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5,
  parameter int IW = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/stack_param.sv
// stack_param: parametrised circular LIFO with status; STACK_PARAM_WRAP_EN makes PUSH-when-full overwrite the oldest entry
module stack_param
  import stack_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 5,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       COMMAND,
  input  logic [IW-1:0]    INDEX,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             DATA_VALID,
  output logic [CW-1:0]    COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ERROR
);
  stack_cmd_e       cmd;
  logic [IW-1:0]    top_q, top_d, rd_addr;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d, rd_data;
  logic             valid_q, valid_d, err_q, err_d, we, full, empty;
  assign cmd   = stack_cmd_e'(COMMAND);
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  // POP reads top-1, GET reads top-1-INDEX; both wrap explicitly mod DEPTH
  assign rd_addr = IW'(ptr_sub(32'(top_q), (cmd == CMD_GET) ? 32'(INDEX) + 1 : 1, DEPTH));
  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IW(IW)) u_mem (
    .clk(CLK), .we(we), .waddr(top_q), .wdata(DATA_IN), .raddr(rd_addr), .rdata(rd_data)
  );
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    we      = 1'b0;
    unique case (cmd)
      CMD_PUSH: begin
        if (!full) begin
          we      = 1'b1;
          top_d   = IW'(ptr_add(32'(top_q), 1, DEPTH));
          count_d = count_q + CW'(1);
        end else begin
`ifdef STACK_PARAM_WRAP_EN
          we    = 1'b1;
          top_d = IW'(ptr_add(32'(top_q), 1, DEPTH));
`else
          err_d = 1'b1;
`endif
        end
      end
      CMD_POP: begin
        if (empty) err_d = 1'b1;
        else begin
          dout_d  = rd_data;
          valid_d = 1'b1;
          top_d   = IW'(ptr_sub(32'(top_q), 1, DEPTH));
          count_d = count_q - CW'(1);
        end
      end
      CMD_GET: begin
        if (32'(INDEX) < 32'(count_q)) begin
          dout_d  = rd_data;
          valid_d = 1'b1;
        end else err_d = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      top_q   <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign DATA_OUT   = dout_q;
  assign DATA_VALID = valid_q;
  assign ERROR      = err_q;
  assign COUNT      = count_q;
  assign FULL       = full;
  assign EMPTY      = empty;
endmodule

// File: tb/tb_stack_param.sv
// tb_stack_param: vector table plus random model-driven scoreboard for stack_param (WIDTH=4, DEPTH=5)
module tb_stack_param;
  import stack_pkg::*;
`ifdef STACK_PARAM_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int DEPTH = 5;
  logic       CLK = 1'b0, RESET = 1'b1, DATA_VALID, FULL, EMPTY, ERROR;
  logic [1:0] COMMAND = 2'b00;
  logic [2:0] INDEX = '0, COUNT;
  logic [3:0] DATA_IN = '0, DATA_OUT;
  int pass_cnt = 0, total_cnt = 0, step = 0;

  typedef struct {
    bit         rst;
    logic [1:0] cmd;
    logic [2:0] idx;
    logic [3:0] din;
    logic [3:0] dout;
    bit         v;
    bit         e;
    int         cnt;
  } rec_t;
  rec_t tbl[$];
  rec_t sb[$];

  stack_param #(.WIDTH(4), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .INDEX(INDEX), .DATA_IN(DATA_IN),
    .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .COUNT(COUNT), .FULL(FULL),
    .EMPTY(EMPTY), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  function automatic void add(bit rst, logic [1:0] c, int i, int d, int o, bit v, bit e, int n);
    tbl.push_back('{rst, c, 3'(i), 4'(d), 4'(o), v, e, n});
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
  endtask

  task automatic run(input rec_t r);
    rec_t x;
    RESET = r.rst; COMMAND = r.cmd; INDEX = r.idx; DATA_IN = r.din;
    sb.push_back(r);
    @(posedge CLK);
    #1;
    x = sb.pop_front();
    cmp("dout", int'(DATA_OUT), int'(x.dout));
    cmp("valid", int'(DATA_VALID), int'(x.v));
    cmp("error", int'(ERROR), int'(x.e));
    cmp("count", int'(COUNT), x.cnt);
    cmp("full", int'(FULL), int'(x.cnt == DEPTH));
    cmp("empty", int'(EMPTY), int'(x.cnt == 0));
    step++;
  endtask

  initial begin
    logic [3:0] model[$];
    logic [3:0] mdout, w;
    logic [1:0] c;
    int i, last;
    // test 1: fill, push when full, drain
    add(1, CMD_NOP, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, CMD_PUSH, 0, k, 0, 0, 0, k);
    add(0, CMD_PUSH, 0, 6, 0, 0, !WRAP, 5);
    for (int k = 0; k < 5; k++) add(0, CMD_POP, 0, 0, (WRAP ? 6 : 5) - k, 1, 0, 4 - k);
    // test 2: drain then pop empty
    last = WRAP ? 2 : 1;
    add(0, CMD_POP, 0, 0, last, 0, 1, 0);
    add(1, CMD_NOP, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, CMD_PUSH, 0, k, 0, 0, 0, k);
    for (int k = 0; k < 5; k++) add(0, CMD_POP, 0, 0, 5 - k, 1, 0, 4 - k);
    add(0, CMD_POP, 0, 0, 1, 0, 1, 0);
    // test 3: GET across the stack and out of range
    add(0, CMD_PUSH, 0, 'hF, 1, 0, 0, 1);
    add(0, CMD_PUSH, 0, 'hE, 1, 0, 0, 2);
    add(0, CMD_PUSH, 0, 'hC, 1, 0, 0, 3);
    add(0, CMD_PUSH, 0, 'h8, 1, 0, 0, 4);
    add(0, CMD_PUSH, 0, 'h0, 1, 0, 0, 5);
    add(0, CMD_GET, 0, 0, 'h0, 1, 0, 5);
    add(0, CMD_GET, 1, 0, 'h8, 1, 0, 5);
    add(0, CMD_GET, 2, 0, 'hC, 1, 0, 5);
    add(0, CMD_GET, 3, 0, 'hE, 1, 0, 5);
    add(0, CMD_GET, 4, 0, 'hF, 1, 0, 5);
    add(0, CMD_GET, 5, 0, 'hF, 0, 1, 5);
    add(0, CMD_GET, 7, 0, 'hF, 0, 1, 5);
    // test 4: pointer wrap
    add(1, CMD_NOP, 0, 0, 0, 0, 0, 0);
    add(0, CMD_PUSH, 0, 'hA, 0, 0, 0, 1);
    add(0, CMD_PUSH, 0, 'hB, 0, 0, 0, 2);
    add(0, CMD_PUSH, 0, 'hC, 0, 0, 0, 3);
    add(0, CMD_POP, 0, 0, 'hC, 1, 0, 2);
    add(0, CMD_POP, 0, 0, 'hB, 1, 0, 1);
    for (int k = 1; k <= 4; k++) add(0, CMD_PUSH, 0, k, 'hB, 0, 0, 1 + k);
    for (int k = 0; k < 4; k++) add(0, CMD_GET, k, 0, 4 - k, 1, 0, 5);
    add(0, CMD_GET, 4, 0, 'hA, 1, 0, 5);
    // test 5: reset beats PUSH
    add(1, CMD_PUSH, 0, 9, 0, 0, 0, 0);
    add(0, CMD_POP, 0, 0, 0, 0, 1, 0);
    // test 6: NOPs interleaved
    add(0, CMD_PUSH, 0, 7, 0, 0, 0, 1);
    add(0, CMD_NOP, 0, 0, 0, 0, 0, 1);
    add(0, CMD_POP, 0, 0, 7, 1, 0, 0);
    add(0, CMD_NOP, 0, 0, 7, 0, 0, 0);
    add(0, CMD_POP, 0, 0, 7, 0, 1, 0);
    add(0, CMD_NOP, 0, 0, 7, 0, 0, 0);
    add(0, CMD_PUSH, 0, 3, 7, 0, 0, 1);
    add(0, CMD_NOP, 0, 0, 7, 0, 0, 1);
    add(0, CMD_GET, 0, 0, 3, 1, 0, 1);
    add(0, CMD_NOP, 0, 0, 3, 0, 0, 1);
    foreach (tbl[k]) run(tbl[k]);
    // random traffic against a queue model (back of queue = newest)
    run('{1, CMD_NOP, 3'd0, 4'd0, 4'd0, 0, 0, 0});
    mdout = '0;
    for (int n = 0; n < 300; n++) begin
      c = 2'($urandom_range(0, 3));
      i = $urandom_range(0, 7);
      w = 4'($urandom);
      case (c)
        CMD_PUSH: begin
          if (model.size() < DEPTH) begin
            model.push_back(w);
            run('{0, c, 3'(i), w, mdout, 0, 0, model.size()});
          end else if (WRAP) begin
            void'(model.pop_front());
            model.push_back(w);
            run('{0, c, 3'(i), w, mdout, 0, 0, model.size()});
          end else run('{0, c, 3'(i), w, mdout, 0, 1, model.size()});
        end
        CMD_POP: begin
          if (model.size() == 0) run('{0, c, 3'(i), w, mdout, 0, 1, 0});
          else begin
            mdout = model.pop_back();
            run('{0, c, 3'(i), w, mdout, 1, 0, model.size()});
          end
        end
        CMD_GET: begin
          if (i < model.size()) begin
            mdout = model[model.size() - 1 - i];
            run('{0, c, 3'(i), w, mdout, 1, 0, model.size()});
          end else run('{0, c, 3'(i), w, mdout, 0, 1, model.size()});
        end
        default: run('{0, c, 3'(i), w, mdout, 0, 0, model.size()});
      endcase
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
